// File: rtl/input_edge_timer.sv
// input_edge_timer
//   Synchronises one asynchronous input, removes glitches with a stability
//   filter, emits registered edge pulses and reports how many clocks each
//   filtered level was held.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-high; clears every flop
//   digital_in   raw asynchronous input
//   level        filtered, synchronised level
//   pos_edge     one-cycle pulse in the first cycle level reads 1
//   neg_edge     one-cycle pulse in the first cycle level reads 0
//   width_valid  one-cycle pulse coincident with pos_edge / neg_edge
//   width        clocks the previous level was held (saturating); holds otherwise
//   width_level  level value that width describes (the pre-edge level)
//   timeout      high while the interval counter is saturated
module input_edge_timer #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int COUNT_WIDTH = 12
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   digital_in,
  output logic                   level,
  output logic                   pos_edge,
  output logic                   neg_edge,
  output logic                   width_valid,
  output logic [COUNT_WIDTH-1:0] width,
  output logic                   width_level,
  output logic                   timeout
);

  localparam int FCW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
  localparam logic [FCW-1:0]         FCNT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = {COUNT_WIDTH{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FCW-1:0]         fcnt_q, fcnt_d;
  logic                   level_q, level_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] width_q, width_d;
  logic                   width_level_q, width_level_d;
  logic                   pos_q, pos_d;
  logic                   neg_q, neg_d;
  logic                   valid_q, valid_d;

  logic s;
  logic toggle;

  assign s = sync_q[SYNC_STAGES-1];

  // Level flips only after s has disagreed with it for FILTER_LEN clocks
  // in a row; any agreement restarts the run.
  assign toggle = (s != level_q) && (fcnt_q == FCNT_LAST);

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], digital_in};

    fcnt_d  = fcnt_q;
    level_d = level_q;
    if (s == level_q) begin
      fcnt_d = '0;
    end else if (toggle) begin
      fcnt_d  = '0;
      level_d = ~level_q;
    end else begin
      fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_comb begin
    width_d       = width_q;
    width_level_d = width_level_q;
    pos_d         = 1'b0;
    neg_d         = 1'b0;
    valid_d       = 1'b0;
    if (toggle) begin
      // cnt already counts the current cycle, so it is the full hold time
      // of the level that is ending; the new level starts at 1.
      width_d       = cnt_q;
      width_level_d = level_q;
      pos_d         = ~level_q;
      neg_d         = level_q;
      valid_d       = 1'b1;
      cnt_d         = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q        <= '0;
      fcnt_q        <= '0;
      level_q       <= 1'b0;
      cnt_q         <= '0;
      width_q       <= '0;
      width_level_q <= 1'b0;
      pos_q         <= 1'b0;
      neg_q         <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      fcnt_q        <= fcnt_d;
      level_q       <= level_d;
      cnt_q         <= cnt_d;
      width_q       <= width_d;
      width_level_q <= width_level_d;
      pos_q         <= pos_d;
      neg_q         <= neg_d;
      valid_q       <= valid_d;
    end
  end

  assign level       = level_q;
  assign pos_edge    = pos_q;
  assign neg_edge    = neg_q;
  assign width_valid = valid_q;
  assign width       = width_q;
  assign width_level = width_level_q;
  assign timeout     = (cnt_q == CNT_MAX);

endmodule
